// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
//   Shared definitions for the set/branch compare arbiter: sequencer states,
//   branch funct3 encodings, requester owner ids and the branch-condition
//   decode helpers used when the shared compare result is registered.
// ---------------------------------------------------------------------------
package cmp_pkg;

    // Sequencer states: wait for a request, evaluate, present the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Branch funct3 encodings
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Requester ids; also the encoding of the round-robin pointer
    localparam logic OWNER_SET = 1'b0;
    localparam logic OWNER_BR  = 1'b1;

    // Branch condition from the three compare flags. The reserved encodings
    // 010/011 never report taken.
    function automatic logic br_taken_fn(input logic [2:0] funct3,
                                         input logic       eq,
                                         input logic       lt,
                                         input logic       ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            BEQ:     taken = eq;
            BNE:     taken = !eq;
            BLT:     taken = lt;
            BGE:     taken = !lt;
            BLTU:    taken = ltu;
            BGEU:    taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic br_illegal_fn(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/cmp_core.sv
// ---------------------------------------------------------------------------
// cmp_core
//   Purely combinational compare datapath shared by both requesters. One
//   XLEN+1 bit subtractor produces all three flags.
//   Ports:
//     rs1, rs2  in   XLEN  operands
//     lt        out  1     signed   rs1 < rs2
//     ltu       out  1     unsigned rs1 < rs2
//     eq        out  1     rs1 == rs2
// ---------------------------------------------------------------------------
module cmp_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            lt,
    output logic            ltu,
    output logic            eq
);

    logic [XLEN:0] diff;

    // Zero-extended subtraction: the extra top bit is the unsigned borrow.
    // For signed compare, differing sign bits decide directly (rs1 negative
    // means less); with equal signs the difference cannot overflow, so its
    // sign bit is the answer.
    assign diff = {1'b0, rs1} - {1'b0, rs2};
    assign ltu  = diff[XLEN];
    assign lt   = (rs1[XLEN-1] != rs2[XLEN-1]) ? rs1[XLEN-1] : diff[XLEN-1];
    assign eq   = (diff[XLEN-1:0] == '0);

endmodule

// File: rtl/set_cmp_arbiter.sv
// ---------------------------------------------------------------------------
// set_cmp_arbiter
//   Shares one compare datapath between the execute-stage set path
//   (SLT/SLTU) and the branch comparator. Round-robin arbitration in IDLE,
//   operands registered on grant, compare evaluated in EXEC, result held in
//   RESP until the owning requester accepts it.
//   Ports:
//     CLK, rst_n            clock, synchronous active-low reset
//     En                    advance enable for IDLE->EXEC and EXEC->RESP
//     flush                 abandon in-flight op, block grants
//     set_req_*/set_rs*     set request handshake and operands
//     set_unsigned          1 = SLTU, 0 = SLT
//     set_rsp_*/set_result  set response handshake and {0..0, lt} result
//     br_req_*/br_rs*       branch request handshake and operands
//     br_funct3             branch condition select
//     br_rsp_*              branch response handshake
//     br_taken/br_illegal   branch outcome, illegal for funct3 010/011
//     busy                  sequencer not idle
// ---------------------------------------------------------------------------
module set_cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            En,
    input  logic            flush,
    input  logic            set_req_valid,
    output logic            set_req_ready,
    input  logic [XLEN-1:0] set_rs1,
    input  logic [XLEN-1:0] set_rs2,
    input  logic            set_unsigned,
    output logic            set_rsp_valid,
    input  logic            set_rsp_ready,
    output logic [XLEN-1:0] set_result,
    input  logic            br_req_valid,
    output logic            br_req_ready,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_rs2,
    input  logic [2:0]      br_funct3,
    output logic            br_rsp_valid,
    input  logic            br_rsp_ready,
    output logic            br_taken,
    output logic            br_illegal,
    output logic            busy
);

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;
    logic            owner_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic            grant_ok;
    logic            grant_set;
    logic            grant_br;
    logic            lt;
    logic            ltu;
    logic            eq;

    cmp_core #(.XLEN(XLEN)) u_cmp_core (
        .rs1 (rs1_q),
        .rs2 (rs2_q),
        .lt  (lt),
        .ltu (ltu),
        .eq  (eq)
    );

    // Sequencer state register
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, handshake outputs and next state. Grants are gated by
    // rst_n so no request is acknowledged while reset is held. When both
    // requesters are valid the round-robin pointer picks the winner.
    always_comb begin
        state_nxt     = state;
        grant_ok      = rst_n && En && !flush && (state == IDLE);
        grant_set     = grant_ok && set_req_valid && (!br_req_valid || rr_ptr == OWNER_SET);
        grant_br      = grant_ok && br_req_valid && (!set_req_valid || rr_ptr == OWNER_BR);
        set_req_ready = grant_set;
        br_req_ready  = grant_br;
        set_rsp_valid = (state == RESP) && (owner_q == OWNER_SET);
        br_rsp_valid  = (state == RESP) && (owner_q == OWNER_BR);
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_set || grant_br) state_nxt = EXEC;
            end
            EXEC: begin
                if (flush)   state_nxt = IDLE;
                else if (En) state_nxt = RESP;
            end
            RESP: begin
                // flush wins over a simultaneous response handshake
                if (flush) begin
                    state_nxt = IDLE;
                end else if ((set_rsp_valid && set_rsp_ready) ||
                             (br_rsp_valid && br_rsp_ready)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on grant and result registration at the end of EXEC.
    // Only the owner's result register is written; the other keeps its last
    // value, qualified by its rsp_valid. A flushed op never writes a result.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            rr_ptr     <= OWNER_SET;
            owner_q    <= OWNER_SET;
            op_q       <= 3'b000;
            rs1_q      <= '0;
            rs2_q      <= '0;
            set_result <= '0;
            br_taken   <= 1'b0;
            br_illegal <= 1'b0;
        end else begin
            if (grant_set || grant_br) begin
                rr_ptr  <= grant_br ? OWNER_SET : OWNER_BR;
                owner_q <= grant_br ? OWNER_BR : OWNER_SET;
                rs1_q   <= grant_br ? br_rs1 : set_rs1;
                rs2_q   <= grant_br ? br_rs2 : set_rs2;
                op_q    <= grant_br ? br_funct3 : {2'b00, set_unsigned};
            end
            if ((state == EXEC) && En && !flush) begin
                if (owner_q == OWNER_SET) begin
                    set_result <= {{(XLEN-1){1'b0}}, (op_q[0] ? ltu : lt)};
                end else begin
                    br_taken   <= br_taken_fn(op_q, eq, lt, ltu);
                    br_illegal <= br_illegal_fn(op_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_set_cmp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_set_cmp_arbiter
//   Self-checking bench for set_cmp_arbiter. A negedge monitor pushes a
//   model result into a per-requester queue whenever a request is accepted
//   and pops/compares it when the matching response handshake occurs.
//   Directed sequences cover latency, contention, backpressure, flush,
//   En stalls and reset in RESP.
// ---------------------------------------------------------------------------
module tb_set_cmp_arbiter;

    localparam int XLEN = 32;
    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic            En;
    logic            flush;
    logic            set_req_valid;
    logic            set_req_ready;
    logic [XLEN-1:0] set_rs1;
    logic [XLEN-1:0] set_rs2;
    logic            set_unsigned;
    logic            set_rsp_valid;
    logic            set_rsp_ready;
    logic [XLEN-1:0] set_result;
    logic            br_req_valid;
    logic            br_req_ready;
    logic [XLEN-1:0] br_rs1;
    logic [XLEN-1:0] br_rs2;
    logic [2:0]      br_funct3;
    logic            br_rsp_valid;
    logic            br_rsp_ready;
    logic            br_taken;
    logic            br_illegal;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] set_q[$];
    logic [31:0] br_q[$];
    int          grant_log[$];
    int          inflight = -1;

    set_cmp_arbiter #(.XLEN(XLEN)) dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .En            (En),
        .flush         (flush),
        .set_req_valid (set_req_valid),
        .set_req_ready (set_req_ready),
        .set_rs1       (set_rs1),
        .set_rs2       (set_rs2),
        .set_unsigned  (set_unsigned),
        .set_rsp_valid (set_rsp_valid),
        .set_rsp_ready (set_rsp_ready),
        .set_result    (set_result),
        .br_req_valid  (br_req_valid),
        .br_req_ready  (br_req_ready),
        .br_rs1        (br_rs1),
        .br_rs2        (br_rs2),
        .br_funct3     (br_funct3),
        .br_rsp_valid  (br_rsp_valid),
        .br_rsp_ready  (br_rsp_ready),
        .br_taken      (br_taken),
        .br_illegal    (br_illegal),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    // Reference results written from the architectural definitions
    function automatic logic [31:0] setModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic u);
        if (u) return {31'b0, (a < b)};
        return {31'b0, ($signed(a) < $signed(b))};
    endfunction

    // Packed as {taken, illegal}
    function automatic logic [31:0] brModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        case (f)
            F_BEQ:   return {30'b0, (a == b), 1'b0};
            F_BNE:   return {30'b0, (a != b), 1'b0};
            F_BLT:   return {30'b0, ($signed(a) < $signed(b)), 1'b0};
            F_BGE:   return {30'b0, ($signed(a) >= $signed(b)), 1'b0};
            F_BLTU:  return {30'b0, (a < b), 1'b0};
            F_BGEU:  return {30'b0, (a >= b), 1'b0};
            default: return {30'b0, 1'b0, 1'b1};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: sample mid-cycle, away from the active edge
    always @(negedge CLK) begin
        checkOutput("one_ready", {31'b0, set_req_ready & br_req_ready}, 32'd0);
        checkOutput("one_rsp_valid", {31'b0, set_rsp_valid & br_rsp_valid}, 32'd0);
        if (!rst_n || flush) begin
            if (inflight == 0 && set_q.size() > 0) void'(set_q.pop_front());
            if (inflight == 1 && br_q.size() > 0) void'(br_q.pop_front());
            inflight = -1;
        end else begin
            if (set_rsp_valid && set_rsp_ready) begin
                if (set_q.size() == 0) checkOutput("set_unexpected_rsp", 32'd1, 32'd0);
                else checkOutput("sb_set_result", set_result, set_q.pop_front());
                inflight = -1;
            end
            if (br_rsp_valid && br_rsp_ready) begin
                if (br_q.size() == 0) checkOutput("br_unexpected_rsp", 32'd1, 32'd0);
                else checkOutput("sb_br_result", {30'b0, br_taken, br_illegal}, br_q.pop_front());
                inflight = -1;
            end
            if (set_req_valid && set_req_ready) begin
                set_q.push_back(setModel(set_rs1, set_rs2, set_unsigned));
                grant_log.push_back(0);
                inflight = 0;
            end
            if (br_req_valid && br_req_ready) begin
                br_q.push_back(brModel(br_rs1, br_rs2, br_funct3));
                grant_log.push_back(1);
                inflight = 1;
            end
        end
    end

    task automatic driveReq(input bit is_br, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f);
        if (is_br) begin
            br_rs1 = a; br_rs2 = b; br_funct3 = f; br_req_valid = 1'b1;
        end else begin
            set_rs1 = a; set_rs2 = b; set_unsigned = f[0]; set_req_valid = 1'b1;
        end
    endtask

    task automatic waitGrant(input bit is_br);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (is_br ? br_req_ready : set_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (is_br) checkOutput("br_grant", {31'b0, got}, 32'd1);
        else checkOutput("set_grant", {31'b0, got}, 32'd1);
    endtask

    task automatic dropReq(input bit is_br);
        @(posedge CLK); #1;
        if (is_br) br_req_valid = 1'b0;
        else set_req_valid = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the granting edge
    task automatic applyStimulus(input bit is_br, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f);
        driveReq(is_br, a, b, f);
        waitGrant(is_br);
        dropReq(is_br);
    endtask

    // Counts negedges until rsp_valid; returns at that negedge
    task automatic waitRsp(input bit is_br, output int cycles);
        bit got;
        got = 1'b0;
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            cycles++;
            if (is_br ? br_rsp_valid : set_rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("rsp_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (!busy) break;
        end
        checkOutput("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        rst_n = 1'b0; En = 1'b1; flush = 1'b0;
        set_req_valid = 1'b1; set_rs1 = '0; set_rs2 = '0; set_unsigned = 1'b0;
        set_rsp_ready = 1'b1;
        br_req_valid = 1'b0; br_rs1 = '0; br_rs2 = '0; br_funct3 = 3'b000;
        br_rsp_ready = 1'b1;

        // Reset state, with a set request pending that must not be granted
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_set_ready", {31'b0, set_req_ready}, 32'd0);
        checkOutput("rst_set_rsp_valid", {31'b0, set_rsp_valid}, 32'd0);
        checkOutput("rst_br_rsp_valid", {31'b0, br_rsp_valid}, 32'd0);
        checkOutput("rst_set_result", set_result, 32'd0);
        checkOutput("rst_br_out", {30'b0, br_taken, br_illegal}, 32'd0);
        @(posedge CLK); #1;
        set_req_valid = 1'b0;
        rst_n = 1'b1;

        // SLTU -5 vs -7 -> 0, response two cycles after grant
        applyStimulus(1'b0, -32'sd5, -32'sd7, 3'b001);
        waitRsp(1'b0, cycles);
        checkOutput("sltu_latency", cycles, 32'd2);
        checkOutput("sltu_result", set_result, 32'd0);
        checkOutput("sltu_busy", {31'b0, busy}, 32'd1);
        @(posedge CLK); #1;

        // SLT -5 vs -3 -> 1
        applyStimulus(1'b0, -32'sd5, -32'sd3, 3'b000);
        waitRsp(1'b0, cycles);
        checkOutput("slt_latency", cycles, 32'd2);
        checkOutput("slt_result", set_result, 32'd1);
        @(posedge CLK); #1;

        // BLTU 1 vs FFFFFFFF -> taken
        applyStimulus(1'b1, 32'd1, 32'hFFFF_FFFF, F_BLTU);
        waitRsp(1'b1, cycles);
        checkOutput("bltu_taken", {30'b0, br_taken, br_illegal}, 32'b10);
        checkOutput("bltu_set_valid", {31'b0, set_rsp_valid}, 32'd0);
        @(posedge CLK); #1;

        // BLT same operands -> not taken
        applyStimulus(1'b1, 32'd1, 32'hFFFF_FFFF, F_BLT);
        waitRsp(1'b1, cycles);
        checkOutput("blt_taken", {30'b0, br_taken, br_illegal}, 32'b00);
        @(posedge CLK); #1;

        // Reserved funct3 -> illegal, not taken
        applyStimulus(1'b1, 32'd7, 32'd7, 3'b010);
        waitRsp(1'b1, cycles);
        checkOutput("illegal_f3", {30'b0, br_taken, br_illegal}, 32'b01);
        @(posedge CLK); #1;

        // Contention: both valid continuously for four grants
        grant_log.delete();
        driveReq(1'b0, 32'd3, 32'd9, 3'b000);
        driveReq(1'b1, 32'd5, 32'd5, F_BEQ);
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (grant_log.size() >= 4) break;
        end
        set_req_valid = 1'b0;
        br_req_valid  = 1'b0;
        waitIdle();
        checkOutput("grant_count", grant_log.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("grant_order", (grant_log.size() > k) ? grant_log[k] : 99, exp_order[k]);
        end

        // Backpressure: result held, pending branch not granted
        set_rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'd3, 32'd7, 3'b000);
        waitRsp(1'b0, cycles);
        @(posedge CLK); #1;
        driveReq(1'b1, 32'd1, 32'd2, F_BNE);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checkOutput("bp_valid", {31'b0, set_rsp_valid}, 32'd1);
            checkOutput("bp_result", set_result, 32'd1);
            checkOutput("bp_no_grant", {31'b0, br_req_ready}, 32'd0);
            checkOutput("bp_busy", {31'b0, busy}, 32'd1);
        end
        @(posedge CLK); #1;
        set_rsp_ready = 1'b1;
        waitGrant(1'b1);
        dropReq(1'b1);
        waitRsp(1'b1, cycles);
        checkOutput("bp_br_latency", cycles, 32'd2);
        checkOutput("bp_br_taken", {30'b0, br_taken, br_illegal}, 32'b10);
        @(posedge CLK); #1;

        // Flush in EXEC: no response, idle next cycle, next op proceeds
        applyStimulus(1'b0, 32'd1, 32'd2, 3'b000);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        checkOutput("fl_exec_busy", {31'b0, busy}, 32'd0);
        checkOutput("fl_exec_valid", {31'b0, set_rsp_valid}, 32'd0);
        @(posedge CLK); #1;
        applyStimulus(1'b1, 32'd4, 32'd4, F_BEQ);
        waitRsp(1'b1, cycles);
        checkOutput("fl_next_latency", cycles, 32'd2);
        checkOutput("fl_next_taken", {30'b0, br_taken, br_illegal}, 32'b10);
        @(posedge CLK); #1;

        // Flush in RESP with rsp_ready high, then flush in IDLE blocks grant
        applyStimulus(1'b0, 32'd1, 32'd2, 3'b000);
        @(posedge CLK); #1;
        flush = 1'b1;
        @(negedge CLK);
        checkOutput("fl_resp_pre_valid", {31'b0, set_rsp_valid}, 32'd1);
        @(posedge CLK); #1;
        driveReq(1'b0, 32'd1, 32'd2, 3'b000);
        @(negedge CLK);
        checkOutput("fl_resp_valid", {31'b0, set_rsp_valid}, 32'd0);
        checkOutput("fl_resp_busy", {31'b0, busy}, 32'd0);
        checkOutput("fl_no_grant", {31'b0, set_req_ready}, 32'd0);
        @(posedge CLK); #1;
        flush = 1'b0;
        waitGrant(1'b0);
        dropReq(1'b0);
        waitRsp(1'b0, cycles);
        checkOutput("fl_resp_next_lat", cycles, 32'd2);
        checkOutput("fl_resp_next_res", set_result, 32'd1);
        @(posedge CLK); #1;

        // En low for three cycles in EXEC stretches latency by three
        applyStimulus(1'b1, 32'd9, 32'd3, F_BGEU);
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("en_hold_valid", {31'b0, br_rsp_valid}, 32'd0);
            checkOutput("en_hold_busy", {31'b0, busy}, 32'd1);
        end
        @(posedge CLK); #1;
        En = 1'b1;
        waitRsp(1'b1, cycles);
        checkOutput("en_latency", cycles + 3, 32'd5);
        checkOutput("en_taken", {30'b0, br_taken, br_illegal}, 32'b10);
        @(posedge CLK); #1;

        // Reset during RESP: outputs cleared, pointer back to set
        set_rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'd1, 32'd2, 3'b000);
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("rr_pre_valid", {31'b0, set_rsp_valid}, 32'd1);
        checkOutput("rr_pre_result", set_result, 32'd1);
        @(posedge CLK); #1;
        rst_n = 1'b0;
        driveReq(1'b0, 32'd1, 32'd2, 3'b000);
        driveReq(1'b1, 32'd1, 32'd2, F_BNE);
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("rr_busy", {31'b0, busy}, 32'd0);
        checkOutput("rr_set_valid", {31'b0, set_rsp_valid}, 32'd0);
        checkOutput("rr_set_result", set_result, 32'd0);
        checkOutput("rr_br_out", {30'b0, br_taken, br_illegal}, 32'd0);
        checkOutput("rr_readies", {30'b0, set_req_ready, br_req_ready}, 32'd0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        set_rsp_ready = 1'b1;
        @(negedge CLK);
        checkOutput("rr_ptr_set_first", {30'b0, set_req_ready, br_req_ready}, 32'b10);
        @(posedge CLK); #1;
        set_req_valid = 1'b0;
        waitRsp(1'b0, cycles);
        checkOutput("rr_post_latency", cycles, 32'd2);
        checkOutput("rr_post_result", set_result, 32'd1);
        waitGrant(1'b1);
        dropReq(1'b1);
        waitRsp(1'b1, cycles);
        checkOutput("rr_post_br", {30'b0, br_taken, br_illegal}, 32'b10);
        waitIdle();

        checkOutput("set_q_drained", set_q.size(), 32'd0);
        checkOutput("br_q_drained", br_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
